// File: rtl/ss_stack.sv
// ss_stack: hardware data stack holding the entries beneath the eJ32 core's
// TOS register. One operation per cycle (NOP/PUSH/POP/REPL), register-array
// storage, current top entry presented combinationally on s.
// Optional feature macro: STACK_ERR_EN -- when defined, ovf/udf become sticky
// overflow/underflow flags; when undefined they are tied to 0.
module ss_stack #(
    parameter int DEPTH = 64,
    parameter int DW    = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [1:0]               op,
    input  logic [DW-1:0]            vi,
    output logic [DW-1:0]            s,
    output logic [$clog2(DEPTH):0]   cnt,
    output logic                     empty,
    output logic                     full,
    output logic                     ovf,
    output logic                     udf
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        OP_NOP  = 2'd0,
        OP_PUSH = 2'd1,
        OP_POP  = 2'd2,
        OP_REPL = 2'd3
    } op_e;

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] push_idx;
    logic [AW-1:0] top_idx;
    logic          do_push;
    logic          do_pop;
    logic          do_repl;
    logic          push_drop;
    logic          pop_drop;

    // Addresses wrap modulo DEPTH; cnt itself saturates and never wraps.
    assign push_idx = cnt[AW-1:0];
    assign top_idx  = cnt[AW-1:0] - AW'(1);

    assign empty = (cnt == '0);
    assign full  = (cnt == CW'(DEPTH));
    assign s     = empty ? '0 : mem[top_idx];

    // Decode the op into qualified actions; REPL on empty degenerates to PUSH,
    // and any unrecognised op value falls through to NOP.
    always_comb begin
        do_push   = 1'b0;
        do_pop    = 1'b0;
        do_repl   = 1'b0;
        push_drop = 1'b0;
        pop_drop  = 1'b0;
        case (op)
            OP_PUSH: begin
                do_push   = !full;
                push_drop = full;
            end
            OP_POP: begin
                do_pop   = !empty;
                pop_drop = empty;
            end
            OP_REPL: begin
                do_repl = !empty;
                do_push = empty;
            end
            default: begin
                do_push = 1'b0;
            end
        endcase
    end

    // Entry count: reset clears it, push/pop step it, REPL leaves it alone.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt <= '0;
        end else if (do_push) begin
            cnt <= cnt + CW'(1);
        end else if (do_pop) begin
            cnt <= cnt - CW'(1);
        end
    end

    // Storage array: never cleared, written by push (next slot) or REPL (top).
    always_ff @(posedge clk) begin
        if (rst) begin
            if (do_push) begin
                mem[push_idx] <= vi;
            end else if (do_repl) begin
                mem[top_idx] <= vi;
            end
        end
    end

`ifdef STACK_ERR_EN
    // Sticky error flags, cleared only by reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            ovf <= 1'b0;
            udf <= 1'b0;
        end else begin
            if (push_drop) begin
                ovf <= 1'b1;
            end
            if (pop_drop) begin
                udf <= 1'b1;
            end
        end
    end
`else
    logic unused_drop;
    assign unused_drop = push_drop | pop_drop;
    assign ovf = 1'b0;
    assign udf = 1'b0;
`endif

endmodule

// File: tb/tb_ss_stack.sv
// tb_ss_stack: directed vector table plus randomized run against a queue-based
// LIFO reference model. Uses DEPTH=4 so the full boundary is reachable quickly.
module tb_ss_stack;

    localparam int DEPTH = 4;
    localparam int DW    = 32;
    localparam int CW    = $clog2(DEPTH) + 1;

`ifdef STACK_ERR_EN
    localparam bit ERR = 1'b1;
`else
    localparam bit ERR = 1'b0;
`endif

    localparam logic [1:0] NOP  = 2'd0;
    localparam logic [1:0] PUSH = 2'd1;
    localparam logic [1:0] POP  = 2'd2;
    localparam logic [1:0] REPL = 2'd3;

    logic          clk;
    logic          rst;
    logic [1:0]    op;
    logic [DW-1:0] vi;
    logic [DW-1:0] s;
    logic [CW-1:0] cnt;
    logic          empty;
    logic          full;
    logic          ovf;
    logic          udf;

    int checks;
    int failures;

    // Reference model: plain LIFO queue plus sticky flags.
    logic [DW-1:0] model_q[$];
    logic          model_ovf;
    logic          model_udf;

    typedef struct {
        logic          rst_n;
        logic [1:0]    op;
        logic [DW-1:0] vi;
        logic [DW-1:0] s;
        int            cnt;
        logic          empty;
        logic          full;
        logic          ovf;
        logic          udf;
        string         name;
    } vec_t;

    vec_t vecs[$];

    ss_stack #(.DEPTH(DEPTH), .DW(DW)) dut (
        .clk   (clk),
        .rst   (rst),
        .op    (op),
        .vi    (vi),
        .s     (s),
        .cnt   (cnt),
        .empty (empty),
        .full  (full),
        .ovf   (ovf),
        .udf   (udf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic rst_n, input logic [1:0] o, input logic [DW-1:0] v,
                                input logic [DW-1:0] es, input int ec, input logic ee,
                                input logic ef, input logic eo, input logic eu, input string nm);
        vec_t r;
        r.rst_n = rst_n; r.op = o; r.vi = v; r.s = es; r.cnt = ec;
        r.empty = ee; r.full = ef; r.ovf = eo; r.udf = eu; r.name = nm;
        return r;
    endfunction

    task automatic modelStep(input logic rst_n, input logic [1:0] o, input logic [DW-1:0] v);
        if (!rst_n) begin
            model_q.delete();
            model_ovf = 1'b0;
            model_udf = 1'b0;
        end else begin
            case (o)
                PUSH: if (model_q.size() < DEPTH) model_q.push_back(v); else if (ERR) model_ovf = 1'b1;
                POP:  if (model_q.size() > 0) void'(model_q.pop_back()); else if (ERR) model_udf = 1'b1;
                REPL: if (model_q.size() > 0) model_q[model_q.size()-1] = v; else model_q.push_back(v);
                default: ;
            endcase
        end
    endtask

    task automatic checkOutput(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic checkState(input string tag, input logic [DW-1:0] es, input int ec,
                              input logic ee, input logic ef, input logic eo, input logic eu);
        checkOutput({tag, ".s"}, s, es);
        checkOutput({tag, ".cnt"}, DW'(cnt), DW'(ec));
        checkOutput({tag, ".empty"}, DW'(empty), DW'(ee));
        checkOutput({tag, ".full"}, DW'(full), DW'(ef));
        checkOutput({tag, ".ovf"}, DW'(ovf), DW'(eo));
        checkOutput({tag, ".udf"}, DW'(udf), DW'(eu));
    endtask

    task automatic checkModel(input string tag);
        logic [DW-1:0] es;
        int            n;
        n  = model_q.size();
        es = (n > 0) ? model_q[n-1] : '0;
        checkState(tag, es, n, n == 0, n == DEPTH, model_ovf, model_udf);
    endtask

    // Drive one cycle's inputs, let the edge execute it, then advance the model.
    task automatic applyStimulus(input logic rst_n, input logic [1:0] o, input logic [DW-1:0] v);
        rst = rst_n;
        op  = o;
        vi  = v;
        @(posedge clk);
        #1;
        modelStep(rst_n, o, v);
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        model_ovf = 1'b0;
        model_udf = 1'b0;
        rst = 1'b0;
        op  = NOP;
        vi  = '0;

        // Reset held with a PUSH pending
        vecs.push_back(mk(0, PUSH, 32'hDEAD_BEEF, 0, 0, 1, 0, 0, 0, "rst0"));
        vecs.push_back(mk(0, PUSH, 32'hDEAD_BEEF, 0, 0, 1, 0, 0, 0, "rst1"));
        // LIFO order
        vecs.push_back(mk(1, PUSH, 1, 1, 1, 0, 0, 0, 0, "lifo_p1"));
        vecs.push_back(mk(1, PUSH, 2, 2, 2, 0, 0, 0, 0, "lifo_p2"));
        vecs.push_back(mk(1, PUSH, 3, 3, 3, 0, 0, 0, 0, "lifo_p3"));
        vecs.push_back(mk(1, POP,  0, 2, 2, 0, 0, 0, 0, "lifo_q1"));
        vecs.push_back(mk(1, POP,  0, 1, 1, 0, 0, 0, 0, "lifo_q2"));
        vecs.push_back(mk(1, POP,  0, 0, 0, 1, 0, 0, 0, "lifo_q3"));
        // REPL on non-empty and on empty
        vecs.push_back(mk(1, PUSH, 32'h11, 32'h11, 1, 0, 0, 0, 0, "repl_p"));
        vecs.push_back(mk(1, REPL, 32'h22, 32'h22, 1, 0, 0, 0, 0, "repl_r"));
        vecs.push_back(mk(1, POP,  0, 0, 0, 1, 0, 0, 0, "repl_q"));
        vecs.push_back(mk(1, REPL, 32'h55, 32'h55, 1, 0, 0, 0, 0, "repl_empty"));
        vecs.push_back(mk(1, POP,  0, 0, 0, 1, 0, 0, 0, "repl_q2"));
        vecs.push_back(mk(1, NOP,  32'h99, 0, 0, 1, 0, 0, 0, "nop_empty"));
        // Full boundary
        vecs.push_back(mk(1, PUSH, 10, 10, 1, 0, 0, 0, 0, "full_p10"));
        vecs.push_back(mk(1, PUSH, 20, 20, 2, 0, 0, 0, 0, "full_p20"));
        vecs.push_back(mk(1, PUSH, 30, 30, 3, 0, 0, 0, 0, "full_p30"));
        vecs.push_back(mk(1, PUSH, 40, 40, 4, 0, 1, 0, 0, "full_p40"));
        vecs.push_back(mk(1, PUSH, 50, 40, 4, 0, 1, ERR, 0, "full_p50"));
        vecs.push_back(mk(1, REPL, 41, 41, 4, 0, 1, ERR, 0, "full_repl"));
        vecs.push_back(mk(1, NOP,  77, 41, 4, 0, 1, ERR, 0, "full_nop"));
        vecs.push_back(mk(1, POP,  0, 30, 3, 0, 0, ERR, 0, "full_pop"));
        vecs.push_back(mk(0, NOP,  0, 0, 0, 1, 0, 0, 0, "full_rst"));
        // Empty boundary
        vecs.push_back(mk(1, POP,  0, 0, 0, 1, 0, 0, ERR, "empty_pop"));
        vecs.push_back(mk(1, PUSH, 7, 7, 1, 0, 0, 0, ERR, "empty_p7"));
        vecs.push_back(mk(0, NOP,  0, 0, 0, 1, 0, 0, 0, "empty_rst"));
        // Reset mid-operation
        vecs.push_back(mk(1, PUSH, 5, 5, 1, 0, 0, 0, 0, "mid_p5"));
        vecs.push_back(mk(1, PUSH, 6, 6, 2, 0, 0, 0, 0, "mid_p6"));
        vecs.push_back(mk(0, PUSH, 9, 0, 0, 1, 0, 0, 0, "mid_rst"));
        vecs.push_back(mk(1, PUSH, 8, 8, 1, 0, 0, 0, 0, "mid_p8"));

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].rst_n, vecs[i].op, vecs[i].vi);
            checkState(vecs[i].name, vecs[i].s, vecs[i].cnt, vecs[i].empty,
                       vecs[i].full, vecs[i].ovf, vecs[i].udf);
        end

        // Back-to-back PUSH then POP restores the previous top
        applyStimulus(0, NOP, 0);
        applyStimulus(1, PUSH, 32'hA5A5_0001);
        applyStimulus(1, PUSH, 32'hA5A5_0002);
        applyStimulus(1, PUSH, 32'hCAFE_F00D);
        checkOutput("b2b_push.s", s, 32'hCAFE_F00D);
        applyStimulus(1, POP, 0);
        checkOutput("b2b_pop.s", s, 32'hA5A5_0002);
        checkOutput("b2b_pop.cnt", DW'(cnt), 32'd2);
        // REPL then POP exposes the untouched entry below
        applyStimulus(1, REPL, 32'h1234_5678);
        checkOutput("b2b_repl.s", s, 32'h1234_5678);
        applyStimulus(1, POP, 0);
        checkOutput("b2b_repl_pop.s", s, 32'hA5A5_0001);
        // Fill to wrap the address bits, then drain and refill
        applyStimulus(1, PUSH, 32'h3);
        applyStimulus(1, PUSH, 32'h4);
        applyStimulus(1, PUSH, 32'h5);
        checkModel("wrap_full");
        applyStimulus(1, POP, 0);
        applyStimulus(1, PUSH, 32'h6);
        checkModel("wrap_refill");

        // Randomized ops with occasional reset, checked against the model
        for (int i = 0; i < 600; i++) begin
            logic          r_n;
            logic [1:0]    o;
            logic [DW-1:0] v;
            r_n = ($urandom_range(0, 39) != 0);
            o   = 2'($urandom_range(0, 3));
            v   = $urandom;
            applyStimulus(r_n, o, v);
            checkModel($sformatf("rand%0d", i));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ss_stack.md
Name: ss_stack

Overview:
- Hardware data stack that implements the slave side of the eJ32 stack-port interface (op, vi in; s out).
- Sits beside the eJ32 core: the core keeps T (TOS) in its own register, and this block holds the entries beneath it, presenting the current top entry on s.
- Register-array storage, single clock, one operation per cycle.

Parameters:
- DEPTH, 64: number of 32-bit entries; power of two, minimum 4.
- DW, 32: data width (matches the core data word).

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst  input  1  reset; synchronous, active-low (rst==0 at a rising clk edge resets).
- op  input  2  stack operation: 0 NOP, 1 PUSH, 2 POP, 3 REPL (overwrite top).
- vi  input  DW  value written by PUSH or REPL.
- s  output  DW  current top entry.
- cnt  output  $clog2(DEPTH)+1  number of valid entries, 0..DEPTH.
- empty  output  1  cnt==0.
- full  output  1  cnt==DEPTH.
- ovf  output  1  sticky overflow flag (see Optional Feature).
- udf  output  1  sticky underflow flag (see Optional Feature).

Behaviour:
- Reset (rst==0 at a clk edge):
  - cnt=0; empty=1, full=0, ovf=0, udf=0, s=0.
  - Array contents are not cleared.
  - Reset wins over any op in the same cycle.
- s is combinational from state:
  - s = mem[cnt-1] when cnt>0, else 0.
  - An op's effect is visible on s/cnt/empty/full immediately after the edge that executes it, i.e. one-cycle latency.
- NOP: no state change.
- PUSH:
  - Not full: mem[cnt]<=vi, cnt<=cnt+1.
  - Full: write dropped, cnt unchanged (saturates, no wrap).
- POP:
  - Not empty: cnt<=cnt-1. The entry is not cleared, and the new s is the next-lower entry, or 0 if now empty.
  - Empty: no change.
- REPL:
  - Not empty: mem[cnt-1]<=vi, cnt unchanged.
  - Empty: behaves exactly as PUSH (cnt becomes 1).
  - Used by the core for combined pop+push (NOS update) in one cycle.
- Back-to-back ops on consecutive cycles are fully supported with no bubbles; PUSH then POP returns the original s.
- Only one op per cycle by construction (op is an encoding, not one-hot).
- Unknown/X op must never corrupt cnt; treat any value outside 0..3 as NOP (relevant only for wider future encodings).
- Read/write address arithmetic is modulo DEPTH, using the low $clog2(DEPTH) bits of cnt or cnt-1. cnt itself never wraps.

Optional Feature:
- Macro: STACK_ERR_EN.
- Defined:
  - ovf sets to 1 on a PUSH attempted while full.
  - udf sets to 1 on a POP attempted while empty.
  - Both are sticky until reset.
  - REPL on empty does not set udf.
- Not defined:
  - ovf and udf are tied to 0.
  - Overflow/underflow handling (drop / no change) is otherwise identical.

Test Plan:
- Reset: drive rst=0 for 2 cycles with op=PUSH, vi=32'hDEAD_BEEF -> cnt=0, empty=1, s=0, ovf=udf=0 after release.
- LIFO order: PUSH 1, PUSH 2, PUSH 3 on consecutive cycles -> s=3, cnt=3. Then POP, POP, POP -> s=2, then 1, then 0; empty=1 after the third POP.
- REPL: PUSH 32'h11, REPL 32'h22 -> s=32'h22, cnt=1. From empty, REPL 32'h55 -> cnt=1, s=32'h55, udf=0.
- Full boundary (DEPTH=4): PUSH 10,20,30,40 -> full=1, s=40. PUSH 50 -> s=40, cnt=4, ovf=1 (STACK_ERR_EN) or 0 (not defined).
- Empty boundary: POP on empty -> cnt=0, s=0, udf=1 (STACK_ERR_EN). udf stays 1 through a subsequent PUSH 7 (s=7) until rst=0.
- Reset mid-operation: PUSH 5, PUSH 6, then rst=0 in the same cycle as PUSH 9 -> cnt=0, s=0. Next PUSH 8 -> s=8, cnt=1.
